// File: rtl/nibble_collector.sv
// Assembles an N-bit word from M-bit nibbles arriving least-significant first,
// presenting it with a one-cycle done pulse; aborts a frame after TIMEOUT idle cycles.
module nibble_collector #(
  parameter int unsigned N       = 32,
  parameter int unsigned M       = 4,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [M-1:0] nib_in,
  input  logic         nib_valid,
  output logic [N-1:0] data,
  output logic         done,
  output logic         busy,
  output logic         err
);

  localparam int unsigned K  = N / M;
  localparam int unsigned CW = $clog2(K) + 1;
  localparam int unsigned GW = $clog2(TIMEOUT) + 1;

  typedef enum logic {IDLE, COLLECT} state_t;

  state_t        state, state_next;
  logic [CW-1:0] cnt, cnt_next;
  logic [GW-1:0] gap, gap_next;
  logic [N-1:0]  shreg, shreg_next;
  logic [N-1:0]  data_next;
  logic          done_next, err_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      gap   <= '0;
      shreg <= '0;
      data  <= '0;
      done  <= 1'b0;
      err   <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      gap   <= gap_next;
      shreg <= shreg_next;
      data  <= data_next;
      done  <= done_next;
      err   <= err_next;
    end
  end

  assign busy = (state == COLLECT);

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    gap_next   = gap;
    shreg_next = shreg;
    data_next  = data;
    done_next  = 1'b0;
    err_next   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = COLLECT;
          cnt_next   = '0;
          gap_next   = '0;
          shreg_next = '0;
        end
      end
      COLLECT: begin
        // start outranks nib_valid, including a would-be final nibble
        if (start) begin
          cnt_next   = '0;
          gap_next   = '0;
          shreg_next = '0;
        end else if (nib_valid) begin
          for (int unsigned i = 0; i < K; i++) begin
            if (cnt == CW'(i)) shreg_next[i*M +: M] = nib_in;
          end
          cnt_next = cnt + CW'(1);
          gap_next = '0;
          if (cnt == CW'(K - 1)) begin
            data_next  = shreg_next;
            done_next  = 1'b1;
            state_next = IDLE;
            cnt_next   = '0;
          end
        end else if (TIMEOUT != 0) begin
          gap_next = gap + GW'(1);
          if (gap_next == GW'(TIMEOUT)) begin
            err_next   = 1'b1;
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule
